// File: rtl/axi_line_fill_if.sv
// rtl/axi_line_fill_if.sv - Miss, AXI read (AR/R) and fill channels of the line-fill engine
// Purpose: bundles every handshake/bus signal of axi_line_fill.
// Ports (signals):
//   miss_*  : miss request from the cache controller (valid/ready/addr)
//   ar*     : AXI4 read-address channel toward memory
//   r*      : AXI4 read-data channel from memory
//   fill_*  : completed line back to the controller (valid/ready/addr/data/err)
// Modports: master = the fill engine, slave = controller plus memory side.
interface axi_line_fill_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int ID_W       = 4
);
  logic                         miss_valid;
  logic                         miss_ready;
  logic [ADDR_W-1:0]            miss_addr;

  logic [ADDR_W-1:0]            araddr;
  logic [7:0]                   arlen;
  logic [2:0]                   arsize;
  logic [1:0]                   arburst;
  logic [ID_W-1:0]              arid;
  logic                         arvalid;
  logic                         arready;

  logic [DATA_W-1:0]            rdata;
  logic [1:0]                   rresp;
  logic                         rlast;
  logic [ID_W-1:0]              rid;
  logic                         rvalid;
  logic                         rready;

  logic                         fill_valid;
  logic                         fill_ready;
  logic [ADDR_W-1:0]            fill_addr;
  logic [LINE_WORDS*DATA_W-1:0] fill_data;
  logic                         fill_err;

  modport master (
    input  miss_valid, miss_addr, arready, rdata, rresp, rlast, rid, rvalid, fill_ready,
    output miss_ready, araddr, arlen, arsize, arburst, arid, arvalid, rready,
           fill_valid, fill_addr, fill_data, fill_err
  );

  modport slave (
    output miss_valid, miss_addr, arready, rdata, rresp, rlast, rid, rvalid, fill_ready,
    input  miss_ready, araddr, arlen, arsize, arburst, arid, arvalid, rready,
           fill_valid, fill_addr, fill_data, fill_err
  );
endinterface

// File: rtl/axi_line_fill.sv
// rtl/axi_line_fill.sv - Cache miss line-fill engine (one INCR burst per line)
// Purpose: takes one miss, issues a single line-sized AXI4 INCR read burst,
// collects the beats into a line buffer and returns the line with an error flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : axi_line_fill_if.master (miss, AR, R and fill channels)
module axi_line_fill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int ID_W       = 4,
  parameter int FILL_ID    = 0
) (
  input  logic            clk,
  input  logic            rst,
  axi_line_fill_if.master bus
);

  localparam int                BEAT_W     = $clog2(LINE_WORDS);
  localparam int                LINE_BYTES = LINE_WORDS * DATA_W / 8;
  localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [DATA_W-1:0] words_q [LINE_WORDS];
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              miss_ready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              fill_valid_q;

  logic              last_beat;
  logic              beat_err;

  assign last_beat = (beat_q == LAST_BEAT);
  // rlast must coincide exactly with the final beat; any mismatch either way is an error.
  assign beat_err  = (bus.rresp != 2'b00) ||
                     (bus.rid != ID_W'(FILL_ID)) ||
                     (bus.rlast != last_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      miss_ready_q <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      fill_valid_q <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.miss_valid && miss_ready_q) begin
            addr_q       <= bus.miss_addr & ~OFF_MASK;
            err_q        <= 1'b0;
            beat_q       <= '0;
            miss_ready_q <= 1'b0;
            arvalid_q    <= 1'b1;
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bus.rvalid && rready_q) begin
            words_q[beat_q] <= bus.rdata;
            if (beat_err) begin
              err_q <= 1'b1;
            end
            // Early rlast ends the fill; unwritten words keep their stale contents.
            if (bus.rlast || last_beat) begin
              rready_q     <= 1'b0;
              fill_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.fill_ready) begin
            fill_valid_q <= 1'b0;
            miss_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.miss_ready = miss_ready_q;
  assign bus.araddr     = addr_q;
  assign bus.arlen      = 8'(LINE_WORDS - 1);
  assign bus.arsize     = 3'($clog2(DATA_W / 8));
  assign bus.arburst    = 2'b01;
  assign bus.arid       = ID_W'(FILL_ID);
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_addr  = addr_q;
  assign bus.fill_err   = err_q;

  always_comb begin
    bus.fill_data = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      bus.fill_data[i*DATA_W +: DATA_W] = words_q[i];
    end
  end

endmodule

// File: tb/tb_axi_line_fill.sv
// tb/tb_axi_line_fill.sv - Directed self-checking bench for axi_line_fill
module tb_axi_line_fill;

  logic clk;
  logic rst;

  axi_line_fill_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8), .ID_W(4)) bus ();

  axi_line_fill #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(8), .ID_W(4), .FILL_ID(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_words [8];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] exp_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = exp_words[i];
    return r;
  endfunction

  // One miss through to fill_valid; returns cycles from miss handshake to the
  // negedge after the final beat (where fill_valid is expected high).
  task automatic run_fill(input logic [31:0] addr, input int ar_delay, input int nbeats,
                          input int last_at, input int bad_beat, input int bad_mode,
                          input logic [31:0] dbase, output int lat);
    logic [31:0] a_exp;
    a_exp = addr & ~32'h1F;
    @(negedge clk);
    check("miss_ready_idle", bus.miss_ready, 1);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    bus.arready    = (ar_delay == 0);
    @(negedge clk);
    lat = 1;
    bus.miss_valid = 1'b0;
    check("arvalid_rise", bus.arvalid, 1);
    check("araddr", bus.araddr, a_exp);
    check("miss_ready_busy", bus.miss_ready, 0);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      lat++;
      check("arvalid_hold", bus.arvalid, 1);
      check("araddr_hold", bus.araddr, a_exp);
      check("rready_in_addr", bus.rready, 0);
    end
    bus.arready = 1'b1;
    @(negedge clk);
    lat++;
    bus.arready = 1'b0;
    check("arvalid_drop", bus.arvalid, 0);
    check("rready_data", bus.rready, 1);
    for (int k = 0; k < nbeats; k++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = dbase + 32'(k);
      bus.rresp  = (bad_mode == 0 && k == bad_beat) ? 2'b10 : 2'b00;
      bus.rid    = (bad_mode == 1 && k == bad_beat) ? 4'h3 : 4'h0;
      bus.rlast  = (k == last_at);
      exp_words[k] = dbase + 32'(k);
      @(negedge clk);
      lat++;
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    bus.rid    = 4'h0;
  endtask

  task automatic take_fill();
    bus.fill_ready = 1'b1;
    @(negedge clk);
    bus.fill_ready = 1'b0;
    check("fill_valid_drop", bus.fill_valid, 0);
    check("miss_ready_back", bus.miss_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    for (int i = 0; i < 8; i++) exp_words[i] = 32'h0;
    rst            = 1'b1;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_1234;
    bus.arready    = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = 2'b00;
    bus.rlast      = 1'b0;
    bus.rid        = 4'h0;
    bus.rvalid     = 1'b0;
    bus.fill_ready = 1'b0;

    // Reset held three cycles with a miss pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_miss_ready", bus.miss_ready, 1);
      check("rst_arvalid", bus.arvalid, 0);
      check("rst_rready", bus.rready, 0);
      check("rst_fill_valid", bus.fill_valid, 0);
    end
    check("arlen", bus.arlen, 7);
    check("arsize", bus.arsize, 2);
    check("arburst", bus.arburst, 1);
    check("arid", bus.arid, 0);
    check("rst_fill_data", bus.fill_data, 0);
    check("rst_fill_err", bus.fill_err, 0);
    bus.miss_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arvalid", bus.arvalid, 0);

    // Clean 8-beat fill.
    run_fill(32'h0000_1234, 0, 8, 7, -1, 0, 32'hA0, lat);
    check("clean_fill_valid", bus.fill_valid, 1);
    check("clean_latency", lat, 10);
    check("clean_fill_addr", bus.fill_addr, 32'h0000_1220);
    check("clean_fill_err", bus.fill_err, 0);
    check("clean_fill_data", bus.fill_data,
          256'h000000a7_000000a6_000000a5_000000a4_000000a3_000000a2_000000a1_000000a0);
    take_fill();

    // arready held off for five cycles.
    run_fill(32'h2000_0010, 5, 8, 7, -1, 0, 32'h10, lat);
    check("stall_fill_valid", bus.fill_valid, 1);
    check("stall_latency", lat, 15);
    check("stall_fill_addr", bus.fill_addr, 32'h2000_0000);
    check("stall_fill_err", bus.fill_err, 0);
    take_fill();

    // SLVERR on beat 3.
    run_fill(32'h0000_4004, 0, 8, 7, 3, 0, 32'hB0, lat);
    check("resp_fill_valid", bus.fill_valid, 1);
    check("resp_fill_err", bus.fill_err, 1);
    check("resp_fill_data", bus.fill_data, exp_line());
    take_fill();

    // Early rlast on beat 5: words 6..7 keep the previous fill's data.
    run_fill(32'h0000_503C, 0, 6, 5, -1, 0, 32'hC0, lat);
    check("early_fill_valid", bus.fill_valid, 1);
    check("early_latency", lat, 8);
    check("early_fill_err", bus.fill_err, 1);
    check("early_stale_words", bus.fill_data[255:192], 64'h000000b7_000000b6);
    check("early_fill_data", bus.fill_data, exp_line());
    take_fill();

    // Missing rlast on the final beat.
    run_fill(32'h0000_6000, 0, 8, 99, -1, 0, 32'hE0, lat);
    check("nolast_fill_valid", bus.fill_valid, 1);
    check("nolast_fill_err", bus.fill_err, 1);
    take_fill();

    // Wrong rid on beat 2.
    run_fill(32'h0000_6100, 0, 8, 7, 2, 1, 32'hF0, lat);
    check("rid_fill_err", bus.fill_err, 1);
    take_fill();

    // Clean fill, then fill_ready withheld for four cycles with a new miss waiting.
    run_fill(32'h0000_8020, 0, 8, 7, -1, 0, 32'hD0, lat);
    check("hold_fill_err", bus.fill_err, 0);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_9000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_fill_valid", bus.fill_valid, 1);
      check("hold_fill_addr", bus.fill_addr, 32'h0000_8020);
      check("hold_fill_data", bus.fill_data, exp_line());
      check("hold_miss_ready", bus.miss_ready, 0);
    end
    bus.fill_ready = 1'b1;
    @(negedge clk);
    bus.fill_ready = 1'b0;
    check("hs_fill_valid", bus.fill_valid, 0);
    check("hs_miss_ready", bus.miss_ready, 1);
    @(negedge clk);
    bus.miss_valid = 1'b0;
    check("next_arvalid", bus.arvalid, 1);
    check("next_araddr", bus.araddr, 32'h0000_9000);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check("next_rready", bus.rready, 1);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hEE;
    @(negedge clk);
    bus.rvalid = 1'b0;

    // Reset while in DATA.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_miss_ready", bus.miss_ready, 1);
    check("mid_rst_rready", bus.rready, 0);
    check("mid_rst_arvalid", bus.arvalid, 0);
    check("mid_rst_fill_data", bus.fill_data, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.fill_valid) seen = 1'b1;
    end
    check("mid_rst_no_fill", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
